// File: rtl/mvm_4_1_8_0.sv
// mvm_4_1_8_0: serial K x K signed matrix-vector multiplier built around one MAC.
// Define MVM_SAT_EN for a saturating accumulator (sticky per row); default build wraps.
module mvm_4_1_8_0 #(
  parameter int K = 4,
  parameter int B = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadMatrix,
  input  logic                  loadVector,
  input  logic                  start,
  output logic                  done,
  input  logic signed [B-1:0]   data_in,
  output logic signed [2*B-1:0] data_out
);

  localparam int PW = 2 * B;
  localparam int MW = $clog2(K * K);
  localparam int VW = $clog2(K);
  localparam logic [MW-1:0] LAST_M = MW'(K * K - 1);
  localparam logic [MW-1:0] LAST_V = MW'(K - 1);
  localparam logic [VW-1:0] LAST_C = VW'(K - 1);

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, DONE, OUTPUT} state_t;

  state_t state, state_nxt;

  // cnt walks a_mem in row-major order; with K a power of two the low bits are the column
  logic [MW-1:0]        cnt;
  logic [VW-1:0]        col;
  logic signed [B-1:0]  a_mem [K*K];
  logic signed [B-1:0]  x_mem [K];
  logic signed [PW-1:0] y_mem [K];
  logic signed [PW-1:0] acc_p0;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] acc_nxt;

  assign col  = cnt[VW-1:0];
  assign prod = PW'(a_mem[cnt]) * PW'(x_mem[col]);

`ifdef MVM_SAT_EN
  logic               sat_p0;
  logic               sat_nxt;
  logic signed [PW:0] sum_w;

  function automatic logic is_sat(input logic signed [PW:0] v);
    return v[PW] != v[PW-1];
  endfunction

  function automatic logic signed [PW-1:0] sat_clip(input logic signed [PW:0] v);
    if (v[PW] != v[PW-1])
      return v[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    return v[PW-1:0];
  endfunction

  always_comb begin
    sum_w = (col == '0) ? (PW+1)'(prod) : (PW+1)'(acc_p0) + (PW+1)'(prod);
    acc_nxt = sat_clip(sum_w);
    sat_nxt = is_sat(sum_w);
    // once a row has clipped it stays at the rail until the next row starts
    if (col != '0 && sat_p0) begin
      acc_nxt = acc_p0;
      sat_nxt = 1'b1;
    end
  end
`else
  assign acc_nxt = (col == '0) ? prod : acc_p0 + prod;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (loadMatrix)      state_nxt = LOAD_M;
        else if (loadVector) state_nxt = LOAD_V;
        else if (start)      state_nxt = COMPUTE;
      end
      LOAD_M:  if (cnt == LAST_M) state_nxt = IDLE;
      LOAD_V:  if (cnt == LAST_V) state_nxt = IDLE;
      COMPUTE: if (cnt == LAST_M) state_nxt = DONE;
      DONE:    state_nxt = OUTPUT;
      OUTPUT:  if (cnt == LAST_V) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture, MAC accumulate, result write-back and drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      done     <= 1'b0;
      data_out <= '0;
      acc_p0   <= '0;
`ifdef MVM_SAT_EN
      sat_p0   <= 1'b0;
`endif
      for (int i = 0; i < K * K; i++) a_mem[i] <= '0;
      for (int i = 0; i < K; i++) begin
        x_mem[i] <= '0;
        y_mem[i] <= '0;
      end
    end else begin
      done <= (state == DONE);
      cnt  <= (state inside {LOAD_M, LOAD_V, COMPUTE, OUTPUT}) ? cnt + MW'(1) : '0;
      case (state)
        LOAD_M: a_mem[cnt] <= data_in;
        LOAD_V: x_mem[col] <= data_in;
        COMPUTE: begin
          acc_p0 <= acc_nxt;
`ifdef MVM_SAT_EN
          sat_p0 <= sat_nxt;
`endif
          if (col == LAST_C) y_mem[cnt[MW-1:VW]] <= acc_nxt;
        end
        OUTPUT: data_out <= y_mem[col];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_4_1_8_0.sv
// Scoreboard bench for mvm_4_1_8_0: directed and random loads/computes against a
// plain-arithmetic model of y = A*x; a monitor checks the K results after each done.
module tb_mvm_4_1_8_0;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               loadMatrix = 1'b0;
  logic               loadVector = 1'b0;
  logic               start = 1'b0;
  logic               done;
  logic signed [7:0]  data_in = '0;
  logic signed [15:0] data_out;

  int am [16];
  int xv [4];
  int sbq [$];
  int ncmp = 0;
  int nmis = 0;

  mvm_4_1_8_0 dut (
    .clk        (clk),
    .reset      (reset),
    .loadMatrix (loadMatrix),
    .loadVector (loadVector),
    .start      (start),
    .done       (done),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_row(input int r);
    int acc = 0;
`ifdef MVM_SAT_EN
    bit stk = 0;
    for (int c = 0; c < 4; c++) begin
      if (!stk) begin
        acc += am[r*4+c] * xv[c];
        if (acc > 32767) begin acc = 32767; stk = 1; end
        else if (acc < -32768) begin acc = -32768; stk = 1; end
      end
    end
    return acc;
`else
    for (int c = 0; c < 4; c++) acc += am[r*4+c] * xv[c];
    return int'(shortint'(acc));
`endif
  endfunction

  task automatic load_m();
    @(negedge clk); loadMatrix = 1'b1;
    @(negedge clk); loadMatrix = 1'b0;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(am[i]);
      @(negedge clk);
    end
  endtask

  task automatic load_v();
    @(negedge clk); loadVector = 1'b1;
    @(negedge clk); loadVector = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'(xv[i]);
      @(negedge clk);
    end
  endtask

  task automatic run(input bit disturb);
    @(negedge clk);
    start = 1'b1;
    for (int r = 0; r < 4; r++) sbq.push_back(ref_row(r));
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (disturb && i == 4) begin start = 1'b1; loadMatrix = 1'b1; data_in = 8'sd99; end
      else if (disturb && i == 7) begin loadVector = 1'b1; data_in = -8'sd77; end
      else begin start = 1'b0; loadMatrix = 1'b0; loadVector = 1'b0; end
      @(negedge clk);
    end
    start = 1'b0; loadMatrix = 1'b0; loadVector = 1'b0;
    chk("drain", sbq.size(), 0);
  endtask

  // Monitor: on a done pulse, pop K expected results and compare on the next K edges
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sbq.size() < 4) begin
          chk("unexpected_done", 1, 0);
        end else begin
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) chk("done_width", int'(done), 0);
            chk($sformatf("y%0d", k), int'(data_out), sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_dout", int'(data_out), 0);
    reset = 1'b1;

    // identity, x=[1,2,3,4], matrix first
    for (int i = 0; i < 16; i++) am[i] = (i % 5 == 0) ? 1 : 0;
    for (int i = 0; i < 4; i++) xv[i] = i + 1;
    load_m(); load_v(); run(0);

    // A=1..16, x all ones, vector first
    for (int i = 0; i < 16; i++) am[i] = i + 1;
    for (int i = 0; i < 4; i++) xv[i] = 1;
    load_v(); load_m(); run(0);

    // extreme negatives: wrap (or saturate)
    for (int i = 0; i < 16; i++) am[i] = -128;
    for (int i = 0; i < 4; i++) xv[i] = -128;
    load_m(); load_v(); run(0);

    // sign extension
    for (int i = 0; i < 16; i++) am[i] = 2;
    for (int i = 0; i < 4; i++) xv[i] = -(i + 1);
    load_m(); load_v(); run(0);

    // control pulses during COMPUTE are ignored; contents unchanged afterwards
    run(1);
    run(0);

    // reset three cycles into a computation
    for (int i = 0; i < 16; i++) am[i] = int'($urandom_range(0, 255)) - 128;
    load_m();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_done", int'(done), 0);
      chk("abort_dout", int'(data_out), 0);
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 16; i++) am[i] = 0;
    for (int i = 0; i < 4; i++) xv[i] = 0;
    run(0);
    for (int i = 0; i < 16; i++) am[i] = (i % 5 == 0) ? 1 : 0;
    for (int i = 0; i < 4; i++) xv[i] = i + 5;
    load_m(); load_v(); run(0);

    // random matrices/vectors, random load order and partial reloads
    for (int it = 0; it < 8; it++) begin
      int mode = int'($urandom_range(0, 2));
      if (mode != 2) for (int i = 0; i < 16; i++) am[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 4; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
      if (mode == 0) begin load_m(); load_v(); end
      else if (mode == 1) begin load_v(); load_m(); end
      else load_v();
      run(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
